ring_stop_buffered: RTL and testbench



---
 rtl/ring_stop_pkg.sv | 29 ++
 rtl/ring_stop_fifo.sv | 64 ++++++
 rtl/ring_stop_buffered.sv | 206 ++++++++++++++++++++
 tb/tb_ring_stop_buffered.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_stop_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ring_stop_pkg
// Purpose : Shared defaults and helper functions for the buffered ring stop.
//           Provides default ring geometry and counter widths, a saturating
//           increment and a one-hot stop-mask generator.
// Revision: 1.0 - initial release
// ============================================================================
package ring_stop_pkg;

    localparam int unsigned C_NUM_STOPS = 8;
    localparam int unsigned C_HOP_W     = 4;
    localparam int unsigned C_CNT_W     = 16;

    // Saturating increment of a counter that is w bits wide (w <= 32).
    // The value is carried in 32 bits; callers cast the result back down.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_val;
        max_val = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v == max_val) ? v : (v + 32'd1);
    endfunction

    // One-hot mask with bit 'id' set; callers cast to the ring width.
    function automatic logic [63:0] onehot_bit(input int unsigned id);
        return 64'd1 << id;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ring_stop_fifo.sv
`default_nettype none
// ============================================================================
// Module  : ring_stop_fifo
// Purpose : Small first-word-fall-through register FIFO. head_o shows the
//           oldest entry whenever empty_o is low. A push is taken when the
//           FIFO is not full, or when it is full and a pop happens in the
//           same cycle.
// Ports   : clk, reset (sync, active-high)
//           push_i/data_i  write side
//           pop_i          remove head (ignored when empty)
//           full_o/empty_o status, derived from registered pointers
//           head_o         current head entry
// Revision: 1.0 - initial release
// ============================================================================
module ring_stop_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);
    assign head_o    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= data_i;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ring_stop_buffered.sv
`default_nettype none
// ============================================================================
// Module  : ring_stop_buffered
// Purpose : Buffered stop on a unidirectional multicast ring. Ejects packets
//           addressed to this stop into an ejection FIFO (stripping its own
//           dest bit), injects queued local packets into free slots (including
//           slots freed by a strip in the same cycle) and keeps starvation,
//           deflection and drop statistics. The ring path never stalls and
//           has exactly one cycle of latency.
// Ports   : clk, reset (sync, active-high), stop_id (static)
//           ring_in_*  / ring_out_*   upstream / downstream slot (out is reg)
//           inj_*                     injection valid/ready handshake
//           ej_*                      ejection valid/ready handshake (FWFT)
//           starve_cnt, deflect_cnt, drop_cnt  saturating statistics
// Config  : `define RING_STOP_TTL_EN enables hop counting and hop-limit drops;
//           when undefined hops pass through and drop_cnt stays 0.
// Revision: 1.0 - initial release
// ============================================================================
module ring_stop_buffered
    import ring_stop_pkg::*;
#(
    parameter int unsigned NUM_STOPS = C_NUM_STOPS,
    parameter int unsigned PAYLOAD_W = 48,
    parameter int unsigned INJ_DEPTH = 4,
    parameter int unsigned EJ_DEPTH  = 4,
    parameter int unsigned HOP_W     = C_HOP_W,
    parameter int unsigned MAX_HOPS  = 12,
    parameter int unsigned CNT_W     = C_CNT_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [$clog2(NUM_STOPS)-1:0] stop_id,
    input  logic                         ring_in_valid,
    input  logic [NUM_STOPS-1:0]         ring_in_dest,
    input  logic [HOP_W-1:0]             ring_in_hops,
    input  logic [PAYLOAD_W-1:0]         ring_in_payload,
    output logic                         ring_out_valid,
    output logic [NUM_STOPS-1:0]         ring_out_dest,
    output logic [HOP_W-1:0]             ring_out_hops,
    output logic [PAYLOAD_W-1:0]         ring_out_payload,
    input  logic                         inj_valid,
    output logic                         inj_ready,
    input  logic [NUM_STOPS-1:0]         inj_dest,
    input  logic [PAYLOAD_W-1:0]         inj_payload,
    output logic                         ej_valid,
    input  logic                         ej_ready,
    output logic [NUM_STOPS-1:0]         ej_dest,
    output logic [PAYLOAD_W-1:0]         ej_payload,
    output logic [CNT_W-1:0]             starve_cnt,
    output logic [CNT_W-1:0]             deflect_cnt,
    output logic [CNT_W-1:0]             drop_cnt
);

    localparam int unsigned ENTRY_W = NUM_STOPS + PAYLOAD_W;

    // ------------------------------------------------------------------
    // Queues
    // ------------------------------------------------------------------
    logic               w_inj_full;
    logic               w_inj_empty;
    logic [ENTRY_W-1:0] w_inj_head;
    logic               w_inj_push;
    logic               w_inj_pop;

    logic               w_ej_full;
    logic               w_ej_empty;
    logic [ENTRY_W-1:0] w_ej_head;
    logic               w_ej_push;
    logic               w_ej_pop;
    logic               w_ej_can_push;

    // An empty destination vector is accepted but never enqueued.
    assign inj_ready  = !w_inj_full;
    assign w_inj_push = inj_valid && !w_inj_full && (inj_dest != '0);

    ring_stop_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (INJ_DEPTH)
    ) u_inj_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_inj_push),
        .pop_i   (w_inj_pop),
        .data_i  ({inj_dest, inj_payload}),
        .full_o  (w_inj_full),
        .empty_o (w_inj_empty),
        .head_o  (w_inj_head)
    );

    assign ej_valid      = !w_ej_empty;
    assign w_ej_pop      = ej_valid && ej_ready;
    // A full ejection queue still accepts when the consumer drains this cycle.
    assign w_ej_can_push = !w_ej_full || w_ej_pop;
    assign ej_dest       = w_ej_head[ENTRY_W-1 -: NUM_STOPS];
    assign ej_payload    = w_ej_head[PAYLOAD_W-1:0];

    ring_stop_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (EJ_DEPTH)
    ) u_ej_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_ej_push),
        .pop_i   (w_ej_pop),
        .data_i  ({ring_in_dest, ring_in_payload}),
        .full_o  (w_ej_full),
        .empty_o (w_ej_empty),
        .head_o  (w_ej_head)
    );

    // ------------------------------------------------------------------
    // Slot logic
    // ------------------------------------------------------------------
    logic [NUM_STOPS-1:0] w_own;
    logic                 w_hit;
    logic                 w_deflect;
    logic                 w_drop;
    logic [NUM_STOPS-1:0] w_fwd_dest;
    logic                 w_fwd_valid;
    logic [HOP_W-1:0]     w_fwd_hops;
    logic                 w_slot_busy;

    logic                 ring_valid_d,   ring_valid_q;
    logic [NUM_STOPS-1:0] ring_dest_d,    ring_dest_q;
    logic [HOP_W-1:0]     ring_hops_d,    ring_hops_q;
    logic [PAYLOAD_W-1:0] ring_payload_d, ring_payload_q;
    logic [CNT_W-1:0]     starve_d,  starve_q;
    logic [CNT_W-1:0]     deflect_d, deflect_q;
    logic [CNT_W-1:0]     drop_d,    drop_q;

    assign w_own = NUM_STOPS'(onehot_bit(32'(stop_id)));

    always_comb begin
        w_hit       = ring_in_valid && ((ring_in_dest & w_own) != '0);
        w_ej_push   = w_hit && w_ej_can_push;
        w_deflect   = w_hit && !w_ej_can_push;
        // Only a successfully ejected packet loses its own bit.
        w_fwd_dest  = w_ej_push ? (ring_in_dest & ~w_own) : ring_in_dest;
        w_fwd_valid = ring_in_valid && (w_fwd_dest != '0);
`ifdef RING_STOP_TTL_EN
        w_fwd_hops  = ring_in_hops + HOP_W'(1);
        // Hop limit applies only to what is left after local ejection.
        w_drop      = w_fwd_valid && (32'(ring_in_hops) >= (MAX_HOPS - 1));
`else
        w_fwd_hops  = ring_in_hops;
        w_drop      = 1'b0;
`endif
        w_slot_busy = w_fwd_valid && !w_drop;
        w_inj_pop   = !w_slot_busy && !w_inj_empty;

        ring_valid_d   = 1'b0;
        ring_dest_d    = '0;
        ring_hops_d    = '0;
        ring_payload_d = '0;
        if (w_inj_pop) begin
            ring_valid_d   = 1'b1;
            ring_dest_d    = w_inj_head[ENTRY_W-1 -: NUM_STOPS];
            ring_hops_d    = '0;
            ring_payload_d = w_inj_head[PAYLOAD_W-1:0];
        end else if (w_slot_busy) begin
            ring_valid_d   = 1'b1;
            ring_dest_d    = w_fwd_dest;
            ring_hops_d    = w_fwd_hops;
            ring_payload_d = ring_in_payload;
        end

        // Starvation runs only while a packet waits and the slot is taken.
        if (!w_inj_empty && w_slot_busy) begin
            starve_d = CNT_W'(sat_inc(32'(starve_q), CNT_W));
        end else begin
            starve_d = '0;
        end
        deflect_d = w_deflect ? CNT_W'(sat_inc(32'(deflect_q), CNT_W)) : deflect_q;
        drop_d    = w_drop    ? CNT_W'(sat_inc(32'(drop_q), CNT_W))    : drop_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ring_valid_q   <= 1'b0;
            ring_dest_q    <= '0;
            ring_hops_q    <= '0;
            ring_payload_q <= '0;
            starve_q       <= '0;
            deflect_q      <= '0;
            drop_q         <= '0;
        end else begin
            ring_valid_q   <= ring_valid_d;
            ring_dest_q    <= ring_dest_d;
            ring_hops_q    <= ring_hops_d;
            ring_payload_q <= ring_payload_d;
            starve_q       <= starve_d;
            deflect_q      <= deflect_d;
            drop_q         <= drop_d;
        end
    end

    assign ring_out_valid   = ring_valid_q;
    assign ring_out_dest    = ring_dest_q;
    assign ring_out_hops    = ring_hops_q;
    assign ring_out_payload = ring_payload_q;
    assign starve_cnt       = starve_q;
    assign deflect_cnt      = deflect_q;
    assign drop_cnt         = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_ring_stop_buffered.sv
`default_nettype none
// ============================================================================
// Module  : tb_ring_stop_buffered
// Purpose : Directed self-checking bench for ring_stop_buffered with
//           NUM_STOPS=8, stop_id=3, EJ_DEPTH=2. Inputs change 1 time unit
//           after the rising edge; outputs are checked at that same point.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ring_stop_buffered;

    localparam int unsigned NS  = 8;
    localparam int unsigned PW  = 48;
    localparam int unsigned HW  = 4;
    localparam int unsigned CW  = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [2:0]    stop_id;
    logic          ring_in_valid;
    logic [NS-1:0] ring_in_dest;
    logic [HW-1:0] ring_in_hops;
    logic [PW-1:0] ring_in_payload;
    logic          ring_out_valid;
    logic [NS-1:0] ring_out_dest;
    logic [HW-1:0] ring_out_hops;
    logic [PW-1:0] ring_out_payload;
    logic          inj_valid;
    logic          inj_ready;
    logic [NS-1:0] inj_dest;
    logic [PW-1:0] inj_payload;
    logic          ej_valid;
    logic          ej_ready;
    logic [NS-1:0] ej_dest;
    logic [PW-1:0] ej_payload;
    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] deflect_cnt;
    logic [CW-1:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ring_stop_buffered #(
        .NUM_STOPS (NS),
        .PAYLOAD_W (PW),
        .INJ_DEPTH (4),
        .EJ_DEPTH  (2),
        .HOP_W     (HW),
        .MAX_HOPS  (12),
        .CNT_W     (CW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stop_id          (stop_id),
        .ring_in_valid    (ring_in_valid),
        .ring_in_dest     (ring_in_dest),
        .ring_in_hops     (ring_in_hops),
        .ring_in_payload  (ring_in_payload),
        .ring_out_valid   (ring_out_valid),
        .ring_out_dest    (ring_out_dest),
        .ring_out_hops    (ring_out_hops),
        .ring_out_payload (ring_out_payload),
        .inj_valid        (inj_valid),
        .inj_ready        (inj_ready),
        .inj_dest         (inj_dest),
        .inj_payload      (inj_payload),
        .ej_valid         (ej_valid),
        .ej_ready         (ej_ready),
        .ej_dest          (ej_dest),
        .ej_payload       (ej_payload),
        .starve_cnt       (starve_cnt),
        .deflect_cnt      (deflect_cnt),
        .drop_cnt         (drop_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ring_in_valid   = 1'b0;
        ring_in_dest    = '0;
        ring_in_hops    = '0;
        ring_in_payload = '0;
        inj_valid       = 1'b0;
        inj_dest        = '0;
        inj_payload     = '0;
    endtask

    task automatic ring(input logic [NS-1:0] d, input logic [HW-1:0] h, input logic [PW-1:0] p);
        ring_in_valid   = 1'b1;
        ring_in_dest    = d;
        ring_in_hops    = h;
        ring_in_payload = p;
    endtask

    task automatic inject(input logic [NS-1:0] d, input logic [PW-1:0] p);
        inj_valid   = 1'b1;
        inj_dest    = d;
        inj_payload = p;
    endtask

    initial begin
        reset    = 1'b1;
        stop_id  = 3'd3;
        ej_ready = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;

        // ---------------- reset state ----------------
        check("rst_ring_valid", 64'(ring_out_valid), 64'd0);
        check("rst_ring_dest",  64'(ring_out_dest),  64'd0);
        check("rst_ej_valid",   64'(ej_valid),       64'd0);
        check("rst_inj_ready",  64'(inj_ready),      64'd1);
        check("rst_counters",   64'({starve_cnt, deflect_cnt, drop_cnt}), 64'd0);

        // ---------------- unicast eject ----------------
        ring(8'h08, 4'd2, 48'h0000_0000_00A1);
        tick();
        idle();
        check("uni_ring_valid", 64'(ring_out_valid), 64'd0);
        check("uni_ej_valid",   64'(ej_valid),       64'd1);
        check("uni_ej_dest",    64'(ej_dest),        64'h08);
        check("uni_ej_payload", 64'(ej_payload),     64'hA1);
        tick();
        check("uni_ej_drained", 64'(ej_valid),       64'd0);

        // ---------------- multicast strip ----------------
        ring(8'h28, 4'd1, 48'h0000_0000_00B2);
        tick();
        idle();
        check("mc_ring_valid", 64'(ring_out_valid), 64'd1);
        check("mc_ring_dest",  64'(ring_out_dest),  64'h20);
`ifdef RING_STOP_TTL_EN
        check("mc_ring_hops",  64'(ring_out_hops),  64'd2);
`else
        check("mc_ring_hops",  64'(ring_out_hops),  64'd1);
`endif
        check("mc_ring_pay",   64'(ring_out_payload), 64'hB2);
        check("mc_ej_dest",    64'(ej_dest),        64'h28);
        check("mc_ej_valid",   64'(ej_valid),       64'd1);
        tick();
        check("mc_slot_idle",  64'(ring_out_valid), 64'd0);

        // ---------------- deflect on full ejection queue ----------------
        ej_ready = 1'b0;
        ring(8'h08, 4'd0, 48'h0000_0000_0C01);
        tick();
        check("dfl_first_free", 64'(ring_out_valid), 64'd0);
        ring(8'h08, 4'd0, 48'h0000_0000_0C02);
        tick();
        check("dfl_second_free", 64'(ring_out_valid), 64'd0);
        ring(8'h08, 4'd0, 48'h0000_0000_0C03);
        tick();
        idle();
        check("dfl_third_valid", 64'(ring_out_valid),   64'd1);
        check("dfl_third_dest",  64'(ring_out_dest),    64'h08);
        check("dfl_third_pay",   64'(ring_out_payload), 64'hC03);
        check("dfl_cnt",         64'(deflect_cnt),      64'd1);
        check("dfl_ej_hold",     64'(ej_payload),       64'hC01);
        ej_ready = 1'b1;
        tick();
        check("dfl_ej_next",     64'(ej_payload),       64'hC02);
        tick();
        check("dfl_ej_empty",    64'(ej_valid),         64'd0);

        // ---------------- injection latency and empty dest ----------------
        inject(8'h02, 48'h0000_0000_0D01);
        tick();
        idle();
        check("inj_lat_t1", 64'(ring_out_valid), 64'd0);
        tick();
        check("inj_lat_t2_valid", 64'(ring_out_valid), 64'd1);
        check("inj_lat_t2_dest",  64'(ring_out_dest),  64'h02);
        check("inj_lat_t2_hops",  64'(ring_out_hops),  64'd0);
        inject(8'h00, 48'h0000_0000_0D02);
        tick();
        idle();
        check("inj_zero_ready", 64'(inj_ready), 64'd1);
        tick();
        check("inj_zero_t1", 64'(ring_out_valid), 64'd0);
        tick();
        check("inj_zero_t2", 64'(ring_out_valid), 64'd0);

        // ---------------- starvation ----------------
        ring(8'h01, 4'd0, 48'h0000_0000_0E00);
        inject(8'h10, 48'h0000_0000_0E10);
        tick();
        inj_valid = 1'b0;
        check("stv_start", 64'(starve_cnt), 64'd0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("stv_count", 64'(starve_cnt), 64'(i));
            check("stv_fwd_dest", 64'(ring_out_dest), 64'h01);
        end
        idle();
        tick();
        check("stv_inj_valid", 64'(ring_out_valid),   64'd1);
        check("stv_inj_dest",  64'(ring_out_dest),    64'h10);
        check("stv_inj_hops",  64'(ring_out_hops),    64'd0);
        check("stv_inj_pay",   64'(ring_out_payload), 64'hE10);
        check("stv_clear",     64'(starve_cnt),       64'd0);

        // ---------------- injection FIFO full ----------------
        ring(8'h01, 4'd0, 48'h0);
        for (int i = 0; i < 4; i++) begin
            inject(8'h10 << i, 48'(i));
            tick();
        end
        check("full_ready", 64'(inj_ready), 64'd0);
        idle();
        tick();
        check("full_drain_dest",  64'(ring_out_dest), 64'h10);
        check("full_drain_ready", 64'(inj_ready),     64'd1);
        tick();
        tick();
        tick();
        check("full_drain_last",  64'(ring_out_dest), 64'h80);
        tick();
        check("full_drained",     64'(ring_out_valid), 64'd0);

        // ---------------- slot reuse ----------------
        ring(8'h01, 4'd0, 48'h0);
        inject(8'h40, 48'h0000_0000_0F40);
        tick();
        inj_valid = 1'b0;
        ring(8'h08, 4'd0, 48'h0000_0000_0F08);
        tick();
        idle();
        check("reuse_valid",   64'(ring_out_valid),   64'd1);
        check("reuse_dest",    64'(ring_out_dest),    64'h40);
        check("reuse_pay",     64'(ring_out_payload), 64'hF40);
        check("reuse_ej_dest", 64'(ej_dest),          64'h08);
        check("reuse_ej_val",  64'(ej_valid),         64'd1);
        tick();

        // ---------------- hop limit ----------------
        ring(8'h01, 4'd11, 48'h0000_0000_0011);
        tick();
        idle();
`ifdef RING_STOP_TTL_EN
        check("ttl_valid", 64'(ring_out_valid), 64'd0);
        check("ttl_drop",  64'(drop_cnt),       64'd1);
`else
        check("ttl_valid", 64'(ring_out_valid), 64'd1);
        check("ttl_hops",  64'(ring_out_hops),  64'd11);
        check("ttl_drop",  64'(drop_cnt),       64'd0);
`endif

        // ---------------- reset mid-operation ----------------
        ring(8'h01, 4'd0, 48'h0);
        inject(8'h20, 48'h0000_0000_0123);
        tick();
        inj_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        check("mrst_ring_valid", 64'(ring_out_valid), 64'd0);
        check("mrst_inj_ready",  64'(inj_ready),      64'd1);
        check("mrst_ej_valid",   64'(ej_valid),       64'd0);
        check("mrst_deflect",    64'(deflect_cnt),    64'd0);
        tick();
        check("mrst_no_inject",  64'(ring_out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
